vga_sync_decoder: RTL and testbench

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_timing_pkg.sv | 30 +++
 rtl/sync_fall_det.sv | 31 +++
 rtl/vga_sync_decoder.sv | 119 +++++++++++
 tb/tb_vga_sync_decoder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and lock-FSM state encoding.
// Used by both the timing generator and vga_sync_decoder so the two sides
// can never disagree about line/frame geometry or the lock state values.
package vga_timing_pkg;

  localparam int VGA_H_TOTAL      = 800;
  localparam int VGA_H_ACTIVE     = 640;
  localparam int VGA_H_SYNC_START = 656;
  localparam int VGA_H_SYNC_W     = 96;
  localparam int VGA_V_TOTAL      = 525;
  localparam int VGA_V_ACTIVE     = 480;
  localparam int VGA_V_SYNC_START = 490;
  localparam int VGA_V_SYNC_W     = 2;
  localparam int VGA_SYNC_LAT     = 3;
  localparam int VGA_LOCK_LINES   = 4;

  typedef logic [9:0] cnt10_t;

  // Lock FSM encoding, kept as plain constants for older consumers.
  typedef logic [1:0] lock_state_t;
  localparam lock_state_t ST_UNLOCKED = 2'd0;
  localparam lock_state_t ST_H_OK     = 2'd1;
  localparam lock_state_t ST_LOCKED   = 2'd2;

  // Increment with wrap back to zero after 'last'.
  function automatic cnt10_t wrap_inc(input cnt10_t v, input cnt10_t last);
    return (v == last) ? '0 : v + 10'd1;
  endfunction

endpackage

// File: rtl/sync_fall_det.sv
// Two-flop synchronizer plus delay flop on an active-low sync pin.
// fall pulses for exactly one cycle after the synchronized level drops.
// Ports:
//   clk  - pixel clock
//   rst  - asynchronous active-high reset; flops idle high (sync inactive)
//   din  - raw asynchronous sync pin
//   fall - one-cycle falling-edge pulse, valid two edges after the pin edge
module sync_fall_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic fall
);

  logic s1, s2, dly;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1  <= 1'b1;
      s2  <= 1'b1;
      dly <= 1'b1;
    end else begin
      s1  <= din;
      s2  <= s1;
      dly <= s2;
    end
  end

  assign fall = ~s2 & dly;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel position and lock status from raw VGA hsync/vsync pins.
// Measures line length and lines-per-frame, reconstructs px_x/px_y aligned
// to the generator's counters (after lock), and flags the visible area.
// Ports:
//   clk, rst          - pixel clock, asynchronous active-high reset
//   hsync_in/vsync_in - active-low sync pins
//   px_x, px_y        - reconstructed column/row
//   de                - visible-area flag (only while locked)
//   locked            - lock FSM in LOCKED
//   line_len          - last measured clocks per line
//   frame_lines       - last measured lines per frame
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL      = VGA_H_TOTAL,
  parameter int H_ACTIVE     = VGA_H_ACTIVE,
  parameter int H_SYNC_START = VGA_H_SYNC_START,
  parameter int V_TOTAL      = VGA_V_TOTAL,
  parameter int V_ACTIVE     = VGA_V_ACTIVE,
  parameter int V_SYNC_START = VGA_V_SYNC_START,
  parameter int SYNC_LAT     = VGA_SYNC_LAT,
  parameter int LOCK_LINES   = VGA_LOCK_LINES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] px_x,
  output logic [9:0] px_y,
  output logic       de,
  output logic       locked,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines
);

  localparam cnt10_t HT      = cnt10_t'(H_TOTAL);
  localparam cnt10_t HA      = cnt10_t'(H_ACTIVE);
  localparam cnt10_t VT      = cnt10_t'(V_TOTAL);
  localparam cnt10_t VA      = cnt10_t'(V_ACTIVE);
  localparam cnt10_t VS_LOAD = cnt10_t'(V_SYNC_START);
  // The fall pulse is acted on SYNC_LAT clocks after the pin edge, so the
  // generator is already that far past the sync start.
  localparam cnt10_t HS_LOAD = cnt10_t'(H_SYNC_START + SYNC_LAT);
  localparam int     GLW     = $clog2(LOCK_LINES + 1);
  localparam logic [GLW-1:0] GL_TGT = GLW'(LOCK_LINES);

  logic        hs_fall, vs_fall;
  cnt10_t      hm, hm_inc, lc, fl_new;
  cnt10_t      px_x_nxt, px_y_nxt;
  logic        px_wrap, hs_good, sync_lost, bad;
  lock_state_t st, st_nxt;
  logic [GLW-1:0] gl, gl_nxt;

  sync_fall_det u_hs (.clk(clk), .rst(rst), .din(hsync_in), .fall(hs_fall));
  sync_fall_det u_vs (.clk(clk), .rst(rst), .din(vsync_in), .fall(vs_fall));

  always_comb begin
    hm_inc    = hm + 10'd1;
    // A line ending in the same cycle as the frame still belongs to it.
    fl_new    = (hs_fall && vs_fall) ? lc + 10'd1 : lc;
    hs_good   = (hm_inc == HT);
    sync_lost = (hm == 10'h3FF);

    px_wrap  = !hs_fall && (px_x == HT - 10'd1);
    px_x_nxt = hs_fall ? HS_LOAD : wrap_inc(px_x, HT - 10'd1);
    px_y_nxt = vs_fall ? VS_LOAD :
               px_wrap ? wrap_inc(px_y, VT - 10'd1) : px_y;

    bad = (hs_fall && !hs_good) || (vs_fall && fl_new != VT) || sync_lost;

    st_nxt = st;
    gl_nxt = gl;
    if (bad) begin
      st_nxt = ST_UNLOCKED;
      gl_nxt = '0;
    end else begin
      if (hs_fall && gl != GL_TGT) gl_nxt = gl + 1'b1;
      case (st)
        ST_UNLOCKED: if (gl_nxt == GL_TGT) st_nxt = ST_H_OK;
        ST_H_OK:     if (vs_fall) st_nxt = ST_LOCKED;
        ST_LOCKED:   st_nxt = ST_LOCKED;
        default:     st_nxt = ST_UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hm          <= '0;
      lc          <= '0;
      gl          <= '0;
      st          <= ST_UNLOCKED;
      px_x        <= '0;
      px_y        <= '0;
      de          <= 1'b0;
      line_len    <= '0;
      frame_lines <= '0;
    end else begin
      // hm saturates so a dead hsync parks it at 1023 (sync-loss marker).
      hm <= hs_fall ? '0 : (sync_lost ? hm : hm_inc);
      if (hs_fall) line_len <= hm_inc;
      if (vs_fall) begin
        frame_lines <= fl_new;
        lc          <= '0;
      end else if (hs_fall) begin
        lc <= lc + 10'd1;
      end
      px_x <= px_x_nxt;
      px_y <= px_y_nxt;
      st   <= st_nxt;
      gl   <= gl_nxt;
      // Computed from next-state values so de lines up with px_x/px_y.
      de   <= (st_nxt == ST_LOCKED) && (px_x_nxt < HA) && (px_y_nxt < VA);
    end
  end

  assign locked = (st == ST_LOCKED);

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder using a scaled-down raster (64x24 total,
// 48x18 active) so several frames fit in a short run; the decoder logic is
// identical for the full 800x525 raster.
module tb_vga_sync_decoder;

  localparam int HT = 64, HA = 48, HS = 52, HW = 8;
  localparam int VT = 24, VA = 18, VS = 20, VW = 2;
  localparam int LAT = 3, LL = 4;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hsync_in, vsync_in;
  logic [9:0] px_x, px_y, line_len, frame_lines;
  logic       de, locked;

  // Timing generator with per-line / per-frame length overrides.
  int hcnt = 0, vcnt = 0;
  int h_tot = HT, v_tot = VT;
  bit hs_hold = 1'b0;

  int checks = 0, failures = 0, de_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (hcnt >= h_tot - 1) begin
      hcnt <= 0;
      vcnt <= (vcnt >= v_tot - 1) ? 0 : vcnt + 1;
    end else begin
      hcnt <= hcnt + 1;
    end
  end

  assign hsync_in = hs_hold || !(hcnt >= HS && hcnt < HS + HW);
  assign vsync_in = !(vcnt >= VS && vcnt < VS + VW);

  vga_sync_decoder #(
    .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HS),
    .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VS),
    .SYNC_LAT(LAT), .LOCK_LINES(LL)
  ) dut (
    .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .px_x(px_x), .px_y(px_y), .de(de), .locked(locked),
    .line_len(line_len), .frame_lines(frame_lines)
  );

  always @(negedge clk) if (!rst && de && !locked) de_bad++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance to the next negedge where the generator is at (h, v); v<0 = any row.
  task automatic wait_pos(input int h, input int v, input int budget, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(hcnt == h && (v < 0 || vcnt == v)) && n < budget);
    if (!(hcnt == h && (v < 0 || vcnt == v))) chk({name, " timeout"}, 0, 1);
  endtask

  task automatic wait_lock(input int budget, input string name);
    int n = 0;
    while (!locked && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(locked), 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " px_x"}, int'(px_x), 0);
    chk({tag, " px_y"}, int'(px_y), 0);
    chk({tag, " de"}, int'(de), 0);
    chk({tag, " locked"}, int'(locked), 0);
    chk({tag, " line_len"}, int'(line_len), 0);
    chk({tag, " frame_lines"}, int'(frame_lines), 0);
  endtask

  typedef struct {
    string name;
    int    kind;      // 0 none, 1 one line of length tot, 2 one frame of tot lines
    int    tot;
    int    exp_len;
    int    exp_lines;
    int    exp_lock;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int pxe, pye, dee, dec, lk;

    vecs[0] = '{"nominal",     0, 0,  64, 24, 1};
    vecs[1] = '{"short_line",  1, 63, 63, 24, 0};
    vecs[2] = '{"long_line",   1, 65, 65, 24, 0};
    vecs[3] = '{"short_frame", 2, 23, 64, 23, 0};
    vecs[4] = '{"long_frame",  2, 25, 64, 25, 0};

    // Reset state, then initial acquisition.
    step(1);
    chk_all_zero("reset");
    step(3);
    rst = 1'b0;
    wait_lock(2 * FRAME, "initial lock within 2 frames");
    chk("initial line_len", int'(line_len), HT);
    chk("initial frame_lines", int'(frame_lines), VT);

    // One full locked frame: position tracking and visible-area coverage.
    pxe = 0; pye = 0; dee = 0; dec = 0;
    for (int n = 0; n < FRAME; n++) begin
      @(negedge clk);
      if (int'(px_x) != hcnt) pxe++;
      if (int'(px_y) != vcnt) pye++;
      if (de != (hcnt < HA && vcnt < VA)) dee++;
      if (de) dec++;
    end
    chk("px_x tracking errors", pxe, 0);
    chk("px_y tracking errors", pye, 0);
    chk("de pattern errors", dee, 0);
    chk("de cycles per frame", dec, HA * VA);

    // Table of single-line / single-frame timing perturbations.
    for (int i = 0; i < 5; i++) begin
      wait_lock(3 * FRAME, {vecs[i].name, " pre-lock"});
      if (vecs[i].kind == 2) begin
        wait_pos(10, 2, 2 * FRAME, vecs[i].name);
        v_tot = vecs[i].tot;
        wait_pos(0, 0, 2 * FRAME, vecs[i].name);
        v_tot = VT;
        wait_pos(LAT - 1, VS, 2 * FRAME, vecs[i].name);
      end else begin
        if (vecs[i].kind == 1) begin
          wait_pos(10, -1, 2 * HT, vecs[i].name);
          h_tot = vecs[i].tot;
          wait_pos(0, -1, 2 * HT, vecs[i].name);
          h_tot = HT;
        end
        wait_pos(HS + LAT - 1, -1, 2 * HT, vecs[i].name);
      end
      // One cycle before the sync is acted on nothing has changed yet.
      chk({vecs[i].name, " locked before"}, int'(locked), 1);
      step(1);
      chk({vecs[i].name, " line_len"}, int'(line_len), vecs[i].exp_len);
      chk({vecs[i].name, " frame_lines"}, int'(frame_lines), vecs[i].exp_lines);
      chk({vecs[i].name, " locked"}, int'(locked), vecs[i].exp_lock);
      if (vecs[i].exp_lock == 0) wait_lock(3 * FRAME, {vecs[i].name, " relock"});
    end

    // hsync stuck high for 1100 clocks: sync loss once hm saturates.
    wait_lock(3 * FRAME, "hold pre-lock");
    wait_pos(HS + LAT, -1, 2 * HT, "hold align");
    step(1);
    hs_hold = 1'b1;
    step(1019);
    chk("hold locked at hm=1020", int'(locked), 1);
    step(5);
    chk("hold locked after hm=1023", int'(locked), 0);
    chk("hold line_len", int'(line_len), HT);
    step(76);
    hs_hold = 1'b0;
    wait_lock(4 * FRAME, "hold relock");

    // Asynchronous reset mid-line, then full reacquisition.
    wait_lock(3 * FRAME, "rst pre-lock");
    wait_pos(30, 5, 2 * FRAME, "rst align");
    chk("px_x before rst", int'(px_x), 30);
    #2 rst = 1'b1;
    #1 chk_all_zero("async rst");
    step(2);
    rst = 1'b0;
    lk = 0;
    // Window spans the first vsync after release, whose partial frame
    // count must not be accepted.
    for (int n = 0; n < (VS - 4) * HT; n++) begin
      @(negedge clk);
      if (locked) lk++;
    end
    chk("locked cycles before reacquire", lk, 0);
    wait_lock(3 * FRAME, "rst relock");
    chk("de while unlocked", de_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
